// File: rtl/arb_pkg.sv
// Shared types and constants for the priority arbiter: FSM state and arbitration modes.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

endpackage

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface priority_arbiter_if #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
);

   logic [N-1:0]  req;
   logic          en;
   logic          done;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_valid;

   modport master (
      output req, en, done,
      input  gnt, gnt_idx, gnt_valid
   );

   modport slave (
      input  req, en, done,
      output gnt, gnt_idx, gnt_valid
   );

endinterface

// File: rtl/prio_enc.sv
// Circular priority search: first set bit of vec_i starting at start_i, walking
// upward (DOWN=0) or downward (DOWN=1) with wrap-around.
module prio_enc #(
   parameter int N    = 8,
   parameter int IW   = $clog2(N),
   parameter bit DOWN = 1'b0
) (
   input  logic [N-1:0]  vec_i,
   input  logic [IW-1:0] start_i,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   always_comb begin
      int p;
      idx_o   = '0;
      found_o = 1'b0;
      p       = 0;
      for (int k = 0; k < N; k++) begin
         if (DOWN) p = (int'(start_i) - k + N) % N;
         else      p = (int'(start_i) + k) % N;
         if (!found_o && vec_i[p]) begin
            found_o = 1'b1;
            idx_o   = IW'(p);
         end
      end
   end

endmodule

// File: rtl/priority_arbiter.sv
// N-way arbiter, fixed-priority or round-robin, holding one registered grant until
// the owner signals done or drops its request; always one idle cycle between grants.
module priority_arbiter
   import arb_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = ARB_FIXED,
   parameter int IW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   priority_arbiter_if.slave  bus
);

   arb_state_e    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          vld_q, vld_d;
   logic [IW-1:0] ptr_q, ptr_d;

   logic [IW-1:0] start_idx;
   logic [IW-1:0] win_idx;
   logic          win_found;

   // Fixed priority is a downward search from the top requester; ptr stays at zero.
   assign start_idx = (MODE == ARB_FIXED) ? IW'(N - 1) : ptr_q;

   prio_enc #(
      .N    (N),
      .IW   (IW),
      .DOWN (MODE == ARB_FIXED)
   ) u_enc (
      .vec_i   (bus.req),
      .start_i (start_idx),
      .idx_o   (win_idx),
      .found_o (win_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.en && win_found) state_d = BUSY;
         BUSY:    if (bus.done || !bus.req[idx_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A release always lands in IDLE with cleared outputs, so new requests seen in
   // the release cycle are arbitrated only on the following edge.
   always_comb begin
      gnt_d = gnt_q;
      idx_d = idx_q;
      vld_d = vld_q;
      ptr_d = ptr_q;
      if (state_q == IDLE && state_d == BUSY) begin
         gnt_d          = '0;
         gnt_d[win_idx] = 1'b1;
         idx_d          = win_idx;
         vld_d          = 1'b1;
         if (MODE == ARB_RR)
            ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end else if (state_d == IDLE) begin
         gnt_d = '0;
         idx_d = '0;
         vld_d = 1'b0;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.gnt_valid = vld_q;

   a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(gnt_q) && (gnt_q[idx_q] == vld_q) && (vld_q == (state_q == BUSY)));

endmodule

// File: tb/tb_priority_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with shared stimulus and checks
// both against a cycle-level behavioural model.
module tb_priority_arbiter;

   localparam int N  = 8;
   localparam int IW = $clog2(N);

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic         en;
   logic         done;

   always #5 clk = ~clk;

   priority_arbiter_if #(.N(N)) if_f ();
   priority_arbiter_if #(.N(N)) if_r ();

   assign if_f.req  = req;
   assign if_f.en   = en;
   assign if_f.done = done;
   assign if_r.req  = req;
   assign if_r.en   = en;
   assign if_r.done = done;

   priority_arbiter #(.N(N), .MODE(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(if_f));
   priority_arbiter #(.N(N), .MODE(1)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(if_r));

   int n_chk  = 0;
   int n_pass = 0;

   // model state per mode: 0 = fixed, 1 = round-robin
   bit m_held [2];
   int m_own  [2];
   int m_ptr  [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int pick(input int m, input logic [N-1:0] r);
      if (m == 0) begin
         for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
      end else begin
         for (int k = 0; k < N; k++) if (r[(m_ptr[1] + k) % N]) return (m_ptr[1] + k) % N;
      end
      return 0;
   endfunction

   function automatic void mdl(input int m, input logic [N-1:0] r, input logic e, input logic d);
      int w;
      if (m_held[m]) begin
         if (d || !r[m_own[m]]) begin
            m_held[m] = 1'b0;
            m_own[m]  = 0;
         end
      end else if (e && r != '0) begin
         w         = pick(m, r);
         m_held[m] = 1'b1;
         m_own[m]  = w;
         if (m == 1) m_ptr[m] = (w + 1) % N;
      end
   endfunction

   function automatic void mdl_reset();
      for (int m = 0; m < 2; m++) begin
         m_held[m] = 1'b0;
         m_own[m]  = 0;
         m_ptr[m]  = 0;
      end
   endfunction

   function automatic logic [31:0] exp_gnt(input int m);
      return m_held[m] ? (32'd1 << m_own[m]) : 32'd0;
   endfunction

   task automatic check_outs();
      chk("fix_gnt", 32'(if_f.gnt),       exp_gnt(0));
      chk("fix_idx", 32'(if_f.gnt_idx),   32'(m_own[0]));
      chk("fix_vld", 32'(if_f.gnt_valid), 32'(m_held[0]));
      chk("rr_gnt",  32'(if_r.gnt),       exp_gnt(1));
      chk("rr_idx",  32'(if_r.gnt_idx),   32'(m_own[1]));
      chk("rr_vld",  32'(if_r.gnt_valid), 32'(m_held[1]));
   endtask

   // called just after a falling edge; applies inputs for one full cycle
   task automatic step(input logic [N-1:0] r, input logic e, input logic d);
      req  = r;
      en   = e;
      done = d;
      @(posedge clk);
      mdl(0, r, e, d);
      mdl(1, r, e, d);
      @(negedge clk);
      check_outs();
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      mdl_reset();
      chk("rst_fix_gnt", 32'(if_f.gnt),       32'd0);
      chk("rst_fix_vld", 32'(if_f.gnt_valid), 32'd0);
      chk("rst_fix_idx", 32'(if_f.gnt_idx),   32'd0);
      chk("rst_rr_vld",  32'(if_r.gnt_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r;
      rst_n = 1'b0;
      req   = '0;
      en    = 1'b0;
      done  = 1'b0;
      mdl_reset();
      repeat (2) @(negedge clk);
      check_outs();
      rst_n = 1'b1;

      // round-robin with all requesting and a done pulse in every busy cycle
      for (int k = 0; k < 9; k++) begin
         step(8'hFF, 1'b1, 1'b0);
         chk("rr_seq", 32'(if_r.gnt_idx), 32'(k % N));
         step(8'hFF, 1'b1, 1'b1);
         chk("rr_gap", 32'(if_r.gnt_valid), 32'd0);
      end

      // steer ptr to 7, then check the wrap between 7 and 0
      step(8'h40, 1'b1, 1'b0);
      step(8'h40, 1'b1, 1'b1);
      step(8'h81, 1'b1, 1'b0);
      chk("rr_wrap7a", 32'(if_r.gnt_idx), 32'd7);
      step(8'h81, 1'b1, 1'b1);
      step(8'h81, 1'b1, 1'b0);
      chk("rr_wrap0", 32'(if_r.gnt_idx), 32'd0);
      step(8'h81, 1'b1, 1'b1);
      step(8'h81, 1'b1, 1'b0);
      chk("rr_wrap7b", 32'(if_r.gnt_idx), 32'd7);
      step(8'h00, 1'b1, 1'b0);

      // fixed priority: highest wins, then the next once 5 lets go
      step(8'h26, 1'b1, 1'b0);
      chk("fix_first", 32'(if_f.gnt), 32'h20);
      step(8'h06, 1'b1, 1'b1);
      chk("fix_idle", 32'(if_f.gnt_valid), 32'd0);
      step(8'h06, 1'b1, 1'b0);
      chk("fix_second", 32'(if_f.gnt), 32'h04);
      step(8'h00, 1'b0, 1'b0);

      // grant held while unrelated bits and en toggle
      step(8'h08, 1'b1, 1'b0);
      chk("hold_start", 32'(if_f.gnt_idx), 32'd3);
      for (int k = 0; k < 4; k++) begin
         r = 8'($urandom) | 8'h08;
         step(r, 1'($urandom), 1'b0);
         chk("hold_idx", 32'(if_f.gnt_idx), 32'd3);
      end
      step(8'hF7, 1'b1, 1'b0);
      chk("drop_vld", 32'(if_f.gnt_valid), 32'd0);
      step(8'h00, 1'b1, 1'b0);

      // enable gating
      for (int k = 0; k < 3; k++) begin
         step(8'h10, 1'b0, 1'b0);
         chk("en_off", 32'(if_f.gnt_valid), 32'd0);
      end
      step(8'h10, 1'b1, 1'b0);
      chk("en_on", 32'(if_f.gnt), 32'h10);

      // reset dropping a live grant, then ptr must restart from 0
      step(8'h10, 1'b1, 1'b1);
      step(8'h04, 1'b1, 1'b0);
      chk("pre_rst", 32'(if_f.gnt), 32'h04);
      async_reset();
      step(8'hFF, 1'b1, 1'b0);
      chk("rr_after_rst", 32'(if_r.gnt_idx), 32'd0);
      step(8'h00, 1'b0, 1'b1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         r = 8'($urandom) & 8'($urandom);
         if (i == 200) async_reset();
         step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter N, default 8, number of requesters (2..32).
REQ-002 Parameter MODE, default 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-003 Parameter IW, default $clog2(N), width of grant index.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  N  request vector, bit i = requester i.
REQ-007 en  input  1  arbitration enable; no new grant issued while low.
REQ-008 done  input  1  owner releases grant this cycle.
REQ-009 gnt  output  N  registered one-hot grant vector.
REQ-010 gnt_idx  output  IW  registered binary index of granted requester.
REQ-011 gnt_valid  output  1  registered, high while a grant is held.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and BUSY, with outputs driven only from registers.
REQ-013 In IDLE with en=1 and req!=0, the block SHALL select a winner, and on the next edge load gnt, gnt_idx and gnt_valid=1 and enter BUSY.
REQ-014 Grant latency SHALL be exactly one cycle from the request sample to gnt_valid=1.
REQ-015 In IDLE with en=0 or req=0, the block SHALL remain in IDLE with gnt=0, gnt_idx=0 and gnt_valid=0.
REQ-016 MODE=0: the highest-index asserted req bit SHALL win.
REQ-017 MODE=1: the first asserted bit at or above pointer ptr SHALL win, searching upward and wrapping from N-1 to 0.
REQ-018 On each grant, ptr SHALL load (winner+1) mod N, wrapping N-1 to 0; MODE=0 SHALL leave ptr unused.
REQ-019 In BUSY, gnt, gnt_idx and ptr SHALL hold constant regardless of req changes on other bits and regardless of en.
REQ-020 In BUSY, done=1 or req[gnt_idx]=0 SHALL release the grant: the next edge clears gnt, gnt_idx and gnt_valid and returns to IDLE.
REQ-021 The block SHALL insert exactly one IDLE cycle between consecutive grants, including a re-grant to the same requester.
REQ-022 In IDLE, done SHALL be ignored.
REQ-023 gnt SHALL always be one-hot or zero, and gnt[gnt_idx] SHALL equal gnt_valid.
REQ-024 A simultaneous release and new requests SHALL be resolved by the next IDLE arbitration, never in the release cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, gnt=0, gnt_idx=0, gnt_valid=0 and ptr=0, independent of clk.
REQ-026 Reset asserted during BUSY SHALL drop the grant asynchronously, with no completion cycle.
REQ-027 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with en=1 and req!=0.

Structure
REQ-028 A shared package arb_pkg SHALL hold the FSM state typedef (IDLE, BUSY) and the mode constants ARB_FIXED=0 and ARB_RR=1.
REQ-029 The winner search SHALL be a combinational sub-module prio_enc, parametrised by N, with inputs vector and start index and outputs index and found.
REQ-030 priority_arbiter SHALL instantiate one prio_enc; MODE=0 SHALL drive start index with N-1 in a downward-search configuration.

Verification
REQ-031 Reset: rst_n=0 mid-BUSY with gnt=8'h04 -> gnt=0, gnt_valid=0 and ptr=0 before the next clk edge.
REQ-032 Fixed priority (N=8, MODE=0): req=8'b0010_0110, en=1 -> one cycle later gnt=8'h20, gnt_idx=5; done pulse -> one IDLE cycle -> gnt=8'h04, idx=2.
REQ-033 Round-robin (MODE=1): req=8'hFF held, done pulsed each BUSY cycle -> idx sequence 0,1,2,...,7,0 with one idle cycle between each grant.
REQ-034 Round-robin wrap: ptr=7, req=8'b1000_0001 -> idx=7, then idx=0, then idx=7.
REQ-035 Hold and release: grant idx=3 held while other req bits toggle -> unchanged; req[3] drops -> gnt_valid=0 next cycle.
REQ-036 Enable gating: req=8'h10, en=0 for 3 cycles -> gnt_valid stays 0; en=1 -> gnt=8'h10 one cycle later.
